// File: rtl/rock_ramp_scheduler.sv
// ============================================================================
// rock_ramp_scheduler : steps rocking amplitude/frequency one unit at a time
// toward a target, dwelling between steps, then strobes a stress evaluation.
// Revision 1.0
// ============================================================================
`default_nettype none

module rock_ramp_scheduler #(
  parameter int DWELL_CYCLES = 1000,
  parameter int OBS_CYCLES   = 5000,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tgtValid,
  input  logic [3:0] tgtA,
  input  logic [3:0] tgtF,
  output logic       tgtReady,
  input  logic       halt,
  output logic [3:0] A,
  output logic [3:0] F,
  output logic       busy,
  output logic       evalStrobe
);

  localparam logic [CNT_W-1:0] C_DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_OBS_LOAD   = CNT_W'(OBS_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RAMP    = 2'd1,
    S_DWELL   = 2'd2,
    S_OBSERVE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       a_q, a_d, f_q, f_d, ta_q, ta_d, tf_q, tf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_f_q, last_f_d;
  logic             halt_run_q, halt_run_d;
  logic             w_accept, w_at_target, w_step_a, w_cnt_zero;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    f_d        = f_q;
    ta_d       = ta_q;
    tf_d       = tf_q;
    cnt_d      = cnt_q;
    last_f_d   = last_f_q;
    halt_run_d = halt_run_q;

    tgtReady    = ((state_q == S_IDLE) || (state_q == S_OBSERVE)) && !halt && !halt_run_q;
    busy        = (state_q != S_IDLE);
    w_accept    = tgtValid && tgtReady;
    w_cnt_zero  = (cnt_q == '0);
    w_at_target = (a_q == ta_q) && (f_q == tf_q);
    w_step_a    = (a_q != ta_q) && (last_f_q || (f_q == tf_q));
    // An abandoned window (new target or halt) never produces a strobe.
    evalStrobe  = (state_q == S_OBSERVE) && w_cnt_zero && !halt_run_q && !w_accept && !halt;

    if (halt) begin
      ta_d       = 4'd0;
      tf_d       = 4'd0;
      halt_run_d = 1'b1;
      if (state_q != S_DWELL) begin
        if ((a_q == 4'd0) && (f_q == 4'd0)) begin
          state_d    = S_IDLE;
          halt_run_d = 1'b0;
        end else begin
          state_d = S_RAMP;
        end
      end
    end else begin
      case (state_q)
        S_RAMP: begin
          if (w_step_a) begin
            a_d      = (a_q < ta_q) ? a_q + 4'd1 : a_q - 4'd1;
            last_f_d = 1'b0;
          end else if (f_q != tf_q) begin
            f_d      = (f_q < tf_q) ? f_q + 4'd1 : f_q - 4'd1;
            last_f_d = 1'b1;
          end
          state_d = S_DWELL;
          cnt_d   = C_DWELL_LOAD;
        end
        S_DWELL: begin
          if (w_cnt_zero) begin
            if (w_at_target) begin
              state_d = S_OBSERVE;
              cnt_d   = C_OBS_LOAD;
            end else begin
              state_d = S_RAMP;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          // IDLE and OBSERVE share the target-accept path.
          if (w_accept) begin
            ta_d = tgtA;
            tf_d = tgtF;
            if ((tgtA == a_q) && (tgtF == f_q)) begin
              state_d = S_OBSERVE;
              cnt_d   = C_OBS_LOAD;
            end else begin
              state_d = S_RAMP;
            end
          end else if (state_q == S_OBSERVE) begin
            if (w_cnt_zero) begin
              state_d    = S_IDLE;
              halt_run_d = 1'b0;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      a_q        <= 4'd0;
      f_q        <= 4'd0;
      ta_q       <= 4'd0;
      tf_q       <= 4'd0;
      cnt_q      <= '0;
      last_f_q   <= 1'b1;
      halt_run_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      f_q        <= f_d;
      ta_q       <= ta_d;
      tf_q       <= tf_d;
      cnt_q      <= cnt_d;
      last_f_q   <= last_f_d;
      halt_run_q <= halt_run_d;
    end
  end

  assign A = a_q;
  assign F = f_q;

endmodule

`default_nettype wire
